// File: rtl/pcm_recorder_if.sv
// Capture-side bus of the PCM recorder: control inputs, status outputs
// and the registered read port used by the playback/CPU side.
interface pcm_recorder_if #(
    parameter int SAMPLES_SIZE = 4096,
    parameter int SAMPLE_WIDTH = 8
);
    localparam int AW = $clog2(SAMPLES_SIZE);
    localparam int LW = $clog2(SAMPLES_SIZE + 1);

    logic                    start;
    logic                    stop;
    logic [SAMPLE_WIDTH-1:0] in;
    logic                    recording;
    logic                    done;
    logic                    wrapped;
    logic [LW-1:0]           length;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_addr;
    logic [SAMPLE_WIDTH-1:0] rd_data;

    modport master (
        output start, stop, in, rd_addr,
        input  recording, done, wrapped, length, wr_ptr, rd_data
    );

    modport slave (
        input  start, stop, in, rd_addr,
        output recording, done, wrapped, length, wr_ptr, rd_data
    );
endinterface

// File: rtl/pcm_recorder.sv
// PCM capture engine: divides clk down to the sample rate and writes one
// sample per address into an on-chip buffer, one-shot or circular.
//
//   state | meaning
//   IDLE  | after reset, nothing captured since
//   REC   | capturing, one write every DIV cycles
//   DONE  | capture ended by stop or (one-shot) buffer full
module pcm_recorder #(
    parameter int SAMPLES_SIZE = 4096,
    parameter int SAMPLE_WIDTH = 8,
    parameter int CLK_FREQ     = 100000000,
    parameter int SAMPLE_FREQ  = 8000,
    parameter int LOOP         = 0
) (
    input logic           clk,
    input logic           rst,
    pcm_recorder_if.slave bus
);
    localparam int DIV = CLK_FREQ / SAMPLE_FREQ;
    localparam int AW  = $clog2(SAMPLES_SIZE);
    localparam int LW  = $clog2(SAMPLES_SIZE + 1);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, REC, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic [AW-1:0]           wr_ptr;
    logic [LW-1:0]           length;
    logic                    wrapped;
    logic [SAMPLE_WIDTH-1:0] rd_data;
    logic [SAMPLE_WIDTH-1:0] mem [SAMPLES_SIZE];

    logic tick;
    logic last;
    logic wr_en;

    assign tick  = (state == REC) && (cnt == CW'(DIV - 1));
    assign last  = (wr_ptr == AW'(SAMPLES_SIZE - 1));
    // stop and start both take precedence over a pending tick
    assign wr_en = tick && !bus.stop && !bus.start;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state: stop beats start beats the buffer-full transition
    always_comb begin
        state_nxt = state;
        if (bus.stop) begin
            if (state == REC) state_nxt = DONE;
        end else if (bus.start) begin
            state_nxt = REC;
        end else if (tick && last && (LOOP == 0)) begin
            state_nxt = DONE;
        end
    end

    // sample-rate divider, write pointer, fill level and wrap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            wr_ptr  <= '0;
            length  <= '0;
            wrapped <= 1'b0;
        end else if (bus.stop) begin
            cnt <= '0;
        end else if (bus.start) begin
            cnt     <= '0;
            wr_ptr  <= '0;
            length  <= '0;
            wrapped <= 1'b0;
        end else if (state == REC) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                if (length != LW'(SAMPLES_SIZE)) length <= length + 1'b1;
                if (last) begin
                    wr_ptr <= '0;
                    if (LOOP != 0) wrapped <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    // sample buffer write; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr] <= bus.in;
    end

    // registered read-first read port
    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[bus.rd_addr];
    end

    assign bus.recording = (state == REC);
    assign bus.done      = (state == DONE);
    assign bus.wrapped   = wrapped;
    assign bus.length    = length;
    assign bus.wr_ptr    = wr_ptr;
    assign bus.rd_data   = rd_data;
endmodule

// File: tb/tb_pcm_recorder.sv
// Directed bench for pcm_recorder: one one-shot and one circular instance
// at DIV=4, depth 8; read-back expectations go through a scoreboard queue.
module tb_pcm_recorder;
    localparam int SS = 8;
    localparam int SW = 8;

    logic clk;
    logic rst0;
    logic rst1;

    pcm_recorder_if #(.SAMPLES_SIZE(SS), .SAMPLE_WIDTH(SW)) b0 ();
    pcm_recorder_if #(.SAMPLES_SIZE(SS), .SAMPLE_WIDTH(SW)) b1 ();

    pcm_recorder #(.SAMPLES_SIZE(SS), .SAMPLE_WIDTH(SW), .CLK_FREQ(40),
                   .SAMPLE_FREQ(10), .LOOP(0)) dut0 (.clk(clk), .rst(rst0), .bus(b0));
    pcm_recorder #(.SAMPLES_SIZE(SS), .SAMPLE_WIDTH(SW), .CLK_FREQ(40),
                   .SAMPLE_FREQ(10), .LOOP(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1));

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] sb [$];
    logic [7:0] rd_exp [8];
    logic [7:0] e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // pipelined read of addresses 0..n-1; each expectation is queued as the
    // address is driven and popped when rd_data is due one edge later
    task automatic read_burst(input bit sel, input int n);
        logic [7:0] x;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                x = sb.pop_front();
                check($sformatf("rd%0d[%0d]", sel, i - 1), sel ? b1.rd_data : b0.rd_data, x);
            end
            if (i < n) begin
                if (sel) b1.rd_addr = 3'(i);
                else     b0.rd_addr = 3'(i);
                sb.push_back(rd_exp[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        b0.start = 1'b0; b0.stop = 1'b0; b0.in = '0; b0.rd_addr = '0;
        b1.start = 1'b0; b1.stop = 1'b0; b1.in = '0; b1.rd_addr = '0;

        // 1. reset state
        @(negedge clk); @(negedge clk);
        check("rst_recording0", b0.recording, 0);
        check("rst_done0",      b0.done,      0);
        check("rst_wrapped0",   b0.wrapped,   0);
        check("rst_length0",    b0.length,    0);
        check("rst_wr_ptr0",    b0.wr_ptr,    0);
        check("rst_rd_data0",   b0.rd_data,   0);
        check("rst_recording1", b1.recording, 0);
        check("rst_done1",      b1.done,      0);
        check("rst_wrapped1",   b1.wrapped,   0);
        check("rst_length1",    b1.length,    0);
        check("rst_wr_ptr1",    b1.wr_ptr,    0);
        check("rst_rd_data1",   b1.rd_data,   0);
        rst0 = 1'b0; rst1 = 1'b0;

        // 2. one-shot fill: in = edge index, writes at edges 4,8,..,32
        b0.start = 1'b1; b0.in = 8'd0;
        @(negedge clk);
        b0.start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            b0.in = 8'(k);
            @(negedge clk);
            if (k == 3) check("t2_len_before_first", b0.length, 0);
            if (k == 4) begin
                check("t2_len_first",    b0.length, 1);
                check("t2_wr_ptr_first", b0.wr_ptr, 1);
            end
            if (k == 31) check("t2_rec_before_full", b0.recording, 1);
        end
        check("t2_done",      b0.done,      1);
        check("t2_recording", b0.recording, 0);
        check("t2_length",    b0.length,    8);
        check("t2_wr_ptr",    b0.wr_ptr,    0);
        for (int k = 33; k <= 40; k++) begin
            b0.in = 8'hEE;
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) rd_exp[i] = 8'(4 * (i + 1));
        read_burst(0, 8);

        // 3. stop at edge 14 after three writes
        b0.start = 1'b1; b0.in = 8'd100;
        @(negedge clk);
        b0.start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            b0.in = 8'(100 + k);
            @(negedge clk);
        end
        b0.stop = 1'b1; b0.in = 8'd114;
        @(negedge clk);
        b0.stop = 1'b0;
        check("t3_done",      b0.done,      1);
        check("t3_recording", b0.recording, 0);
        check("t3_length",    b0.length,    3);
        check("t3_wr_ptr",    b0.wr_ptr,    3);
        rd_exp = '{8'd104, 8'd108, 8'd112, 8'd16, 8'd20, 8'd24, 8'd28, 8'd32};
        read_burst(0, 8);

        // stop together with start while recording -> DONE
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        check("t3_restart_rec", b0.recording, 1);
        b0.start = 1'b1; b0.stop = 1'b1;
        @(negedge clk);
        b0.start = 1'b0; b0.stop = 1'b0;
        check("t3_stopstart_done", b0.done,      1);
        check("t3_stopstart_rec",  b0.recording, 0);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check("t3_idle_done", b0.done, 0);
        // stop in IDLE, alone and with start, leaves IDLE untouched
        b0.stop = 1'b1;
        @(negedge clk);
        check("t3_stop_idle_rec",  b0.recording, 0);
        check("t3_stop_idle_done", b0.done,      0);
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0; b0.stop = 1'b0;
        check("t3_stopstart_idle_rec",  b0.recording, 0);
        check("t3_stopstart_idle_done", b0.done,      0);

        // 4. circular capture, 10 ticks at edges 4..40
        b1.start = 1'b1; b1.in = 8'd0;
        @(negedge clk);
        b1.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            b1.in = 8'(k);
            @(negedge clk);
            if (k == 31) check("t4_wrapped_before", b1.wrapped, 0);
            if (k == 32) begin
                check("t4_wrapped_at_full", b1.wrapped, 1);
                check("t4_wr_ptr_at_full",  b1.wr_ptr,  0);
                check("t4_len_at_full",     b1.length,  8);
            end
        end
        check("t4_recording", b1.recording, 1);
        check("t4_length",    b1.length,    8);
        check("t4_wrapped",   b1.wrapped,   1);
        check("t4_wr_ptr",    b1.wr_ptr,    2);
        b1.stop = 1'b1;
        @(negedge clk);
        b1.stop = 1'b0;
        check("t4_done",         b1.done,    1);
        check("t4_wrapped_held", b1.wrapped, 1);
        rd_exp = '{8'd36, 8'd40, 8'd12, 8'd16, 8'd20, 8'd24, 8'd28, 8'd32};
        read_burst(1, 8);

        // 5. restart after five ticks
        b1.start = 1'b1; b1.in = 8'd50;
        @(negedge clk);
        b1.start = 1'b0;
        check("t5_wrapped_cleared", b1.wrapped, 0);
        check("t5_len_cleared",     b1.length,  0);
        for (int k = 1; k <= 20; k++) begin
            b1.in = 8'(50 + k);
            @(negedge clk);
        end
        check("t5_len_5",    b1.length, 5);
        check("t5_wr_ptr_5", b1.wr_ptr, 5);
        b1.start = 1'b1; b1.in = 8'd71;
        @(negedge clk);
        b1.start = 1'b0;
        check("t5_restart_len",    b1.length,    0);
        check("t5_restart_wr_ptr", b1.wr_ptr,    0);
        check("t5_restart_wrap",   b1.wrapped,   0);
        check("t5_restart_rec",    b1.recording, 1);
        for (int k = 22; k <= 24; k++) begin
            b1.in = 8'(50 + k);
            @(negedge clk);
        end
        check("t5_len_before_write", b1.length, 0);
        b1.in = 8'd75; b1.rd_addr = 3'd0; sb.push_back(8'd54);
        @(negedge clk);
        check("t5_len_after_write",    b1.length, 1);
        check("t5_wr_ptr_after_write", b1.wr_ptr, 1);
        e = sb.pop_front();
        check("t5_read_first", b1.rd_data, e);
        sb.push_back(8'd75); b1.in = 8'd76;
        @(negedge clk);
        e = sb.pop_front();
        check("t5_read_new", b1.rd_data, e);

        // 6. reset at edge 10 of a capture
        b0.start = 1'b1; b0.in = 8'd150;
        @(negedge clk);
        b0.start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            b0.in = 8'(150 + k);
            @(negedge clk);
        end
        check("t6_len_before_rst", b0.length, 2);
        rst0 = 1'b1; b0.in = 8'd160;
        @(negedge clk);
        check("t6_rec",     b0.recording, 0);
        check("t6_done",    b0.done,      0);
        check("t6_length",  b0.length,    0);
        check("t6_wr_ptr",  b0.wr_ptr,    0);
        check("t6_rd_data", b0.rd_data,   0);
        rst0 = 1'b0;
        for (int k = 11; k <= 20; k++) begin
            b0.in = 8'(150 + k);
            @(negedge clk);
        end
        check("t6_idle_rec", b0.recording, 0);
        check("t6_idle_len", b0.length,    0);
        rd_exp[0] = 8'd154; rd_exp[1] = 8'd158; rd_exp[2] = 8'd112; rd_exp[3] = 8'd16;
        read_burst(0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
